// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus arbitration slice.
// Provides default bus widths and the arbiter state encoding.
package wb_pkg;

  localparam int unsigned WB_ADR_WIDTH = 32;
  localparam int unsigned WB_DAT_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: chooses the first requester strictly after the
// previously granted one, wrapping around to index 0.
// Ports:
//   req   - request vector, bit i = requester i
//   last  - one-hot previous winner (all-zero treated as "before bit 0")
//   next  - one-hot winner, zero when nothing requests
//   valid - at least one requester present
module rr_picker #(
  parameter int unsigned M_COUNT = 2
) (
  input  logic [M_COUNT-1:0] req,
  input  logic [M_COUNT-1:0] last,
  output logic [M_COUNT-1:0] next,
  output logic               valid
);

  localparam logic [M_COUNT-1:0] ONE = {{(M_COUNT-1){1'b0}}, 1'b1};

  logic [M_COUNT-1:0] upper_mask;
  logic [M_COUNT-1:0] req_upper;

  always_comb begin
    // Bits strictly above the last winner; empty when last is the MSB.
    upper_mask = ~((last << 1) - ONE);
    req_upper  = req & upper_mask;
    // Isolate the lowest set bit (x & -x), preferring the upper half so
    // the search wraps only when nothing above last is requesting.
    if (|req_upper) begin
      next = req_upper & (~req_upper + ONE);
    end else begin
      next = req & (~req + ONE);
    end
    valid = |req;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B3 classic slave port between
// M_COUNT masters. Grant is held for the full bus cycle (m_cyc high).
// Optional watchdog: define WB_ARB_TIMEOUT_EN to add a stalled-slave timeout
// that retries the owner, drops the grant and sets sticky timeout_err.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   m_adr/m_datwr/m_sel     - packed master request fields, master i at slice i
//   m_we/m_stb/m_cyc        - per-master control
//   m_datrd/m_ack/m_rty     - responses routed back (ack/rty only to owner)
//   s_*                     - shared slave port
//   grant                   - one-hot owner, zero when idle
//   timeout_err             - sticky watchdog flag (WB_ARB_TIMEOUT_EN only)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned M_COUNT        = 2,
  parameter int unsigned ADR_WIDTH      = WB_ADR_WIDTH,
  parameter int unsigned DAT_WIDTH      = WB_DAT_WIDTH,
  parameter int unsigned SEL_WIDTH      = DAT_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [M_COUNT*ADR_WIDTH-1:0]   m_adr,
  input  logic [M_COUNT*DAT_WIDTH-1:0]   m_datwr,
  input  logic [M_COUNT*SEL_WIDTH-1:0]   m_sel,
  input  logic [M_COUNT-1:0]             m_we,
  input  logic [M_COUNT-1:0]             m_stb,
  input  logic [M_COUNT-1:0]             m_cyc,
  output logic [DAT_WIDTH-1:0]           m_datrd,
  output logic [M_COUNT-1:0]             m_ack,
  output logic [M_COUNT-1:0]             m_rty,
  output logic [ADR_WIDTH-1:0]           s_adr,
  output logic [DAT_WIDTH-1:0]           s_datwr,
  output logic [SEL_WIDTH-1:0]           s_sel,
  output logic                           s_we,
  output logic                           s_stb,
  output logic                           s_cyc,
  input  logic [DAT_WIDTH-1:0]           s_datrd,
  input  logic                           s_ack,
  input  logic                           s_rty,
  output logic [M_COUNT-1:0]             grant
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  // Master 0 gets top priority out of reset.
  localparam logic [M_COUNT-1:0] LAST_RST = {1'b1, {(M_COUNT-1){1'b0}}};

  arb_state_t         state;
  logic [M_COUNT-1:0] last_grant;
  logic [M_COUNT-1:0] pick;
  logic               pick_valid;
  logic               arbitrate;
  logic               timeout_hit;

  rr_picker #(
    .M_COUNT (M_COUNT)
  ) u_picker (
    .req   (m_cyc),
    .last  (last_grant),
    .next  (pick),
    .valid (pick_valid)
  );

  assign arbitrate = (state == IDLE) || !(|(m_cyc & grant));

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Fires during the TIMEOUT_CYCLES-th unanswered strobe cycle.
  assign timeout_hit = s_stb && !s_ack && !s_rty && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_RST;
    end else if (timeout_hit) begin
      // last_grant already points at the hung owner, so it loses priority.
      state <= IDLE;
      grant <= '0;
    end else if (arbitrate) begin
      if (pick_valid) begin
        state      <= OWNED;
        grant      <= pick;
        last_grant <= pick;
      end else begin
        state <= IDLE;
        grant <= '0;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Arbitration in OWNED only happens once the owner's cyc is low, so
  // clearing on arbitrate covers every grant change.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if (timeout_hit || s_ack || s_rty || arbitrate) begin
        tmo_cnt <= '0;
      end else if (s_stb) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    s_adr   = '0;
    s_datwr = '0;
    s_sel   = '0;
    for (int unsigned i = 0; i < M_COUNT; i++) begin
      if (grant[i]) begin
        s_adr   = m_adr[i*ADR_WIDTH +: ADR_WIDTH];
        s_datwr = m_datwr[i*DAT_WIDTH +: DAT_WIDTH];
        s_sel   = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign s_we  = |(m_we & grant);
  assign s_cyc = |(m_cyc & grant);
  assign s_stb = |(m_stb & m_cyc & grant);

  assign m_datrd = s_datrd;
  assign m_ack   = {M_COUNT{s_ack}} & grant;
  assign m_rty   = {M_COUNT{s_rty || timeout_hit}} & grant;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] m_adr;
  logic [63:0] m_datwr;
  logic [7:0]  m_sel;
  logic [1:0]  m_we;
  logic [1:0]  m_stb;
  logic [1:0]  m_cyc;
  logic [31:0] m_datrd;
  logic [1:0]  m_ack;
  logic [1:0]  m_rty;
  logic [31:0] s_adr;
  logic [31:0] s_datwr;
  logic [3:0]  s_sel;
  logic        s_we;
  logic        s_stb;
  logic        s_cyc;
  logic [31:0] s_datrd;
  logic        s_ack;
  logic        s_rty;
  logic [1:0]  grant;
`ifdef WB_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int checks   = 0;
  int failures = 0;
  int n_g0     = 0;
  int n_g1     = 0;

  always #5 clock = ~clock;

  wb_arbiter #(
    .M_COUNT        (2),
    .ADR_WIDTH      (32),
    .DAT_WIDTH      (32),
    .SEL_WIDTH      (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m_adr   (m_adr),
    .m_datwr (m_datwr),
    .m_sel   (m_sel),
    .m_we    (m_we),
    .m_stb   (m_stb),
    .m_cyc   (m_cyc),
    .m_datrd (m_datrd),
    .m_ack   (m_ack),
    .m_rty   (m_rty),
    .s_adr   (s_adr),
    .s_datwr (s_datwr),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_stb   (s_stb),
    .s_cyc   (s_cyc),
    .s_datrd (s_datrd),
    .s_ack   (s_ack),
    .s_rty   (s_rty),
    .grant   (grant)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    m_adr   = '0;
    m_datwr = '0;
    m_sel   = '0;
    m_we    = '0;
    m_stb   = '0;
    m_cyc   = '0;
    s_datrd = '0;
    s_ack   = 1'b0;
    s_rty   = 1'b0;
    m_adr[31:0]    = 32'h0000_0100;
    m_adr[63:32]   = 32'h0000_0200;
    m_datwr[31:0]  = 32'hA5A5_0001;
    m_datwr[63:32] = 32'h5A5A_0002;
    m_sel          = 8'h3F;

    // Reset state
    do_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("rst_s_stb", 64'(s_stb), 64'h0);
    chk("rst_m_ack", 64'(m_ack), 64'h0);
    chk("rst_m_rty", 64'(m_rty), 64'h0);

    // Single request from master 0, ack in the third cycle
    m_cyc = 2'b01;
    m_stb = 2'b01;
    m_we  = 2'b01;
    #1;
    chk("single_same_cycle_cyc", 64'(s_cyc), 64'h0);
    tick();
    #1;
    chk("single_grant", 64'(grant), 64'h1);
    chk("single_s_adr", 64'(s_adr), 64'h100);
    chk("single_s_datwr", 64'(s_datwr), 64'hA5A5_0001);
    chk("single_s_sel", 64'(s_sel), 64'hF);
    chk("single_s_we", 64'(s_we), 64'h1);
    chk("single_s_stb", 64'(s_stb), 64'h1);
    chk("single_m_ack_wait", 64'(m_ack), 64'h0);
    tick();
    s_ack   = 1'b1;
    s_datrd = 32'hDEAD_BEEF;
    #1;
    chk("single_m_ack", 64'(m_ack), 64'h1);
    chk("single_m_datrd", 64'(m_datrd), 64'hDEAD_BEEF);
    tick();
    s_ack = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    m_we  = 2'b00;
    #1;
    chk("single_drop_s_cyc", 64'(s_cyc), 64'h0);
    chk("single_drop_s_adr_held", 64'(s_adr), 64'h100);
    tick();
    #1;
    chk("single_idle_grant", 64'(grant), 64'h0);
    chk("single_idle_s_adr", 64'(s_adr), 64'h0);
    s_datrd = 32'h1234_5678;
    #1;
    chk("datrd_broadcast_idle", 64'(m_datrd), 64'h1234_5678);

    // Contention right after reset: master 0 first
    do_reset();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    tick();
    s_ack = 1'b1;
    #1;
    chk("cont_grant0", 64'(grant), 64'h1);
    chk("cont_s_adr0", 64'(s_adr), 64'h100);
    chk("cont_m_ack0", 64'(m_ack), 64'h1);
    tick();
    s_ack = 1'b0;
    m_cyc = 2'b10;
    m_stb = 2'b10;
    #1;
    chk("cont_handover_s_cyc", 64'(s_cyc), 64'h0);
    chk("cont_handover_grant", 64'(grant), 64'h1);
    tick();
    #1;
    chk("cont_grant1", 64'(grant), 64'h2);
    chk("cont_s_adr1", 64'(s_adr), 64'h200);
    chk("cont_s_datwr1", 64'(s_datwr), 64'h5A5A_0002);
    s_ack = 1'b1;
    #1;
    chk("cont_m_ack1", 64'(m_ack), 64'h2);
    tick();
    s_ack = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // Fairness: continuous requests, 1-beat transfers; last owner was master 1
    m_cyc = 2'b11;
    m_stb = 2'b11;
    tick();
    for (int t = 0; t < 8; t++) begin
      logic [1:0] exp_g;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      m_cyc = 2'b11;
      m_stb = 2'b11;
      s_ack = 1'b1;
      #1;
      chk("fair_grant", 64'(grant), 64'(exp_g));
      chk("fair_m_ack", 64'(m_ack), 64'(exp_g));
      if (grant == 2'b01) n_g0++;
      if (grant == 2'b10) n_g1++;
      tick();
      s_ack = 1'b0;
      m_cyc = 2'b11 & ~exp_g;
      m_stb = 2'b11 & ~exp_g;
      #1;
      chk("fair_drop_s_cyc", 64'(s_cyc), 64'h0);
      tick();
    end
    chk("fair_count_m0", 64'(n_g0), 64'd4);
    chk("fair_count_m1", 64'(n_g1), 64'd4);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();
    tick();

    // Locked cycle: master 0 holds cyc across a 2-cycle stb gap
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    s_ack = 1'b1;
    #1;
    chk("lock_beat1_ack", 64'(m_ack), 64'h1);
    tick();
    s_ack = 1'b0;
    m_stb = 2'b10;
    #1;
    chk("lock_gap1_grant", 64'(grant), 64'h1);
    chk("lock_gap1_s_stb", 64'(s_stb), 64'h0);
    chk("lock_gap1_s_cyc", 64'(s_cyc), 64'h1);
    tick();
    #1;
    chk("lock_gap2_grant", 64'(grant), 64'h1);
    tick();
    m_stb = 2'b11;
    s_ack = 1'b1;
    #1;
    chk("lock_beat2_grant", 64'(grant), 64'h1);
    chk("lock_beat2_ack", 64'(m_ack), 64'h1);
    tick();
    #1;
    chk("lock_beat3_ack", 64'(m_ack), 64'h1);
    tick();
    s_ack = 1'b0;
    m_cyc = 2'b10;
    m_stb = 2'b10;
    #1;
    chk("lock_release_grant", 64'(grant), 64'h1);
    tick();
    #1;
    chk("lock_next_grant", 64'(grant), 64'h2);
    chk("lock_next_s_stb", 64'(s_stb), 64'h1);

    // Reset while master 1 owns with stb high
    m_cyc = 2'b11;
    m_stb = 2'b11;
    reset = 1'b1;
    tick();
    #1;
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_s_cyc", 64'(s_cyc), 64'h0);
    chk("midrst_s_stb", 64'(s_stb), 64'h0);
    reset = 1'b0;
    tick();
    #1;
    chk("midrst_winner", 64'(grant), 64'h1);

`ifdef WB_ARB_TIMEOUT_EN
    // Master 0 is in its 1st unanswered stb cycle
    chk("tmo_err_clear", 64'(timeout_err), 64'h0);
    for (int c = 1; c < 4; c++) begin
      chk("tmo_no_rty", 64'(m_rty), 64'h0);
      tick();
      #1;
    end
    chk("tmo_rty_owner", 64'(m_rty), 64'h1);
    tick();
    #1;
    chk("tmo_err_set", 64'(timeout_err), 64'h1);
    chk("tmo_idle_grant", 64'(grant), 64'h0);
    tick();
    #1;
    chk("tmo_other_grant", 64'(grant), 64'h2);
`endif

    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
